// File: rtl/mau_pkg.sv
// mau_pkg: size encodings, FSM states and default memory size shared by mem_access_unit.
package mau_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  localparam int unsigned MEM_BYTES_DEF = 256;
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, RESP} state_t;
endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: big-endian lane select/extend for loads and lane merge for sub-word stores.
// Only present when MAU_SUBWORD_EN is defined.
`ifdef MAU_SUBWORD_EN
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [15:0] sdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [15:0] lane;
  always_comb begin
    sh = size_i == SZ_BYTE ? {~addr_i, 3'b000} : size_i == SZ_HALF ? {~addr_i[1], 4'b0000} : 5'd0;
    mask = size_i == SZ_BYTE ? 32'h0000_00FF : size_i == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    lane = 16'(word_i >> sh);
    load_o = size_i == SZ_BYTE ? {{24{signed_i & lane[7]}}, lane[7:0]} :
             size_i == SZ_HALF ? {{16{signed_i & lane[15]}}, lane} : word_i;
    store_o = (word_i & ~(mask << sh)) | (({16'h0000, sdata_i} & mask) << sh);
  end
endmodule
`endif

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a big-endian, byte-addressed memory port.
// Define MAU_SUBWORD_EN for byte/halfword accesses; otherwise only word accesses are legal.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respData,
  output logic        respErr,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        err_q, err_d, req_err, rd_to_wr;
  logic [31:0] rd_val, merged;
`ifdef MAU_SUBWORD_EN
  logic [1:0]  lane_q, lane_d, size_q, size_d;
  logic        sgn_q, sgn_d, write_q, write_d;
  logic [15:0] sdata_q, sdata_d;
  mau_lane_align u_align (
    .word_i  (memReadData),
    .addr_i  (lane_q),
    .size_i  (size_q),
    .signed_i(sgn_q),
    .sdata_i (sdata_q),
    .load_o  (rd_val),
    .store_o (merged)
  );
  assign rd_to_wr = write_q;
  assign req_err  = reqSize == SZ_ILL || (reqSize == SZ_HALF && reqAddr[0]) ||
                    (reqSize == SZ_WORD && reqAddr[1:0] != 2'b00) || reqAddr >= 32'(MEM_BYTES);
`else
  logic unused_sgn;
  assign unused_sgn = reqSigned;
  assign rd_val     = memReadData;
  assign merged     = memReadData;
  assign rd_to_wr   = 1'b0;
  assign req_err    = reqSize != SZ_WORD || reqAddr[1:0] != 2'b00 || reqAddr >= 32'(MEM_BYTES);
`endif
  assign memAddress   = addr_q;
  assign memWriteData = wdata_q;
  assign respData     = rdata_q;
  assign respErr      = err_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef MAU_SUBWORD_EN
    lane_d  = lane_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    write_d = write_q;
    sdata_d = sdata_q;
`endif
    case (state_q)
      IDLE: if (reqValid) begin
`ifdef MAU_SUBWORD_EN
        lane_d  = reqAddr[1:0];
        size_d  = reqSize;
        sgn_d   = reqSigned;
        write_d = reqWrite;
        sdata_d = reqData[15:0];
`endif
        err_d   = req_err;
        rdata_d = '0;
        if (req_err) state_d = RESP;
        else begin
          addr_d = {reqAddr[31:2], 2'b00};
          // word stores skip the read; everything else reads the word first
          if (reqWrite && reqSize == SZ_WORD) begin
            wdata_d = reqData;
            state_d = WR_SETUP;
          end else state_d = RD;
        end
      end
      RD: if (rd_to_wr) begin
        wdata_d = merged;
        state_d = WR_SETUP;
      end else begin
        rdata_d = rd_val;
        state_d = RESP;
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = RESP;
      RESP:     state_d = respReady ? IDLE : RESP;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
`ifdef MAU_SUBWORD_EN
      lane_q    <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      write_q   <= 1'b0;
      sdata_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      reqReady  <= state_d == IDLE;
      respValid <= state_d == RESP;
      MemRead   <= state_d == RD;
      MemWrite  <= state_d == WR_PULSE;
`ifdef MAU_SUBWORD_EN
      lane_q    <= lane_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      write_q   <= write_d;
      sdata_q   <= sdata_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: bench with a byte-array memory, a transaction-level reference model and directed + random requests.
module tb_mem_access_unit;
`ifdef MAU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        reqValid = 1'b0, reqWrite = 1'b0, reqSigned = 1'b0, respReady = 1'b0;
  logic [1:0]  reqSize = 2'b10;
  logic [31:0] reqAddr = '0, reqData = '0;
  logic        reqReady, respValid, respErr, MemRead, MemWrite;
  logic [31:0] respData, memAddress, memWriteData, memReadData;
  logic [7:0]  mem   [256];
  logic [7:0]  ref_m [256];
  int nchk = 0, nerr = 0, wr_cyc = 0, rd_cyc = 0;
  bit          busy = 1'b0, err_m, wr_m, rd_m;
  int          c, lat_m, al_m;
  logic [31:0] ed_m, ww_m;
  logic [7:0]  wb [4];

  mem_access_unit #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
    .respValid(respValid), .respReady(respReady), .respData(respData), .respErr(respErr),
    .MemRead(MemRead), .MemWrite(MemWrite), .memAddress(memAddress), .memWriteData(memWriteData),
    .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  assign memReadData = MemRead ? {mem[{memAddress[7:2], 2'd0}], mem[{memAddress[7:2], 2'd1}],
                                  mem[{memAddress[7:2], 2'd2}], mem[{memAddress[7:2], 2'd3}]} : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: level-sensitive write strobe, sampled on the clock
  always @(posedge clk) begin
    if (MemWrite) begin
      for (int i = 0; i < 4; i++) mem[{memAddress[7:2], 2'(i)}] = memWriteData[31-8*i -: 8];
      wr_cyc++;
    end
    if (MemRead) rd_cyc++;
  end

  // reference model: transaction timeline counted in edges since acceptance
  always @(posedge clk) begin
    int n, ai;
    logic [31:0] v;
    if (!rst_n) busy = 1'b0;
    else if (!busy) begin
      if (reqValid) begin
        wr_m  = reqWrite;
        n     = reqSize == 2'd0 ? 1 : reqSize == 2'd1 ? 2 : 4;
        err_m = reqAddr >= 32'd256 || reqSize == 2'd3 || (reqSize == 2'd1 && reqAddr[0]) ||
                (reqSize == 2'd2 && reqAddr[1:0] != 2'd0) || (!SUB && reqSize != 2'd2);
        ai    = int'(reqAddr[7:0]);
        al_m  = ai & ~3;
        lat_m = err_m ? 1 : !wr_m ? 2 : reqSize == 2'd2 ? 3 : 4;
        rd_m  = !err_m && (!wr_m || reqSize != 2'd2);
        ed_m  = '0;
        ww_m  = '0;
        if (!err_m) begin
          for (int i = 0; i < 4; i++) wb[i] = ref_m[al_m+i];
          if (wr_m) for (int i = 0; i < n; i++) wb[ai-al_m+i] = 8'(reqData >> (8*(n-1-i)));
          else begin
            v = '0;
            for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, ref_m[ai+i]};
            if (reqSigned && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            ed_m = v;
          end
          ww_m = {wb[0], wb[1], wb[2], wb[3]};
        end
        busy = 1'b1;
        c = 1;
      end
    end else if (c >= lat_m && respReady) busy = 1'b0;
    else begin
      if (wr_m && !err_m && c == lat_m - 1) for (int i = 0; i < 4; i++) ref_m[al_m+i] = wb[i];
      c++;
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("reqReady", reqReady, !busy);
    chk("respValid", respValid, busy && c >= lat_m);
    chk("MemRead", MemRead, busy && rd_m && c == 1);
    chk("MemWrite", MemWrite, busy && wr_m && !err_m && c == lat_m - 1);
    if (busy && c >= lat_m) begin
      chk("respData", respData, ed_m);
      chk("respErr", respErr, err_m);
    end
    if (busy && !err_m) chk("memAddress", memAddress, al_m);
    if (busy && wr_m && !err_m && c >= lat_m - 2) chk("memWriteData", memWriteData, ww_m);
  end

  task automatic xact(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a, input logic [31:0] d,
                      input int hold, input bit junk, output logic [31:0] rd, output logic re, output int lat);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqData = d; respReady = 1'b0;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      reqValid = junk; reqAddr = $urandom; reqData = $urandom; reqWrite = 1'($urandom); reqSize = 2'($urandom);
      if (respValid) lat = k;
    end
    rd = respData;
    re = respErr;
    if (lat == 0) begin
      nchk++; nerr++;
      $display("FAIL resp_timeout: respValid not seen within 20 cycles at %0t", $time);
      reqValid = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    reqValid = 1'b0; respReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    respReady = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r_d, old40;
    logic        r_e;
    int          r_l, w0, r0, mism;
    bit          seen;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ref_m[i] = mem[i]; end
    #1 rst_n = 1'b0;
    #2;
    chk("rst_reqReady", reqReady, 1);
    chk("rst_respValid", respValid, 0);
    chk("rst_strobes", {MemRead, MemWrite}, 0);
    chk("rst_resp", {respErr, respData}, 0);
    chk("rst_mem_bus", {memAddress, memWriteData}, 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

    w0 = wr_cyc;
    xact(1, 2'd2, 0, 20, 32'hDEADBEEF, 0, 0, r_d, r_e, r_l);
    chk("sw20_lat", r_l, 3);
    chk("sw20_resp", {r_e, r_d}, 0);
    chk("sw20_pulses", wr_cyc - w0, 1);
    chk("sw20_mem", {mem[20], mem[21], mem[22], mem[23]}, 32'hDEADBEEF);
    xact(0, 2'd2, 0, 20, 0, 0, 0, r_d, r_e, r_l);
    chk("lw20", {r_e, r_d}, {1'b0, 32'hDEADBEEF});
    chk("lw20_lat", r_l, 2);

    xact(1, 2'd2, 0, 8, 32'h11223344, 0, 0, r_d, r_e, r_l);
    xact(1, 2'd0, 0, 10, 32'h000000AA, 0, 0, r_d, r_e, r_l);
    chk("sb10_lat", r_l, SUB ? 4 : 1);
    chk("sb10_mem", {mem[8], mem[9], mem[10], mem[11]}, SUB ? 32'h1122AA44 : 32'h11223344);
    xact(0, 2'd0, 1, 10, 0, 0, 0, r_d, r_e, r_l);
    chk("lbs10", {r_e, r_d}, SUB ? {1'b0, 32'hFFFFFFAA} : {1'b1, 32'h0});
    xact(0, 2'd0, 0, 10, 0, 0, 0, r_d, r_e, r_l);
    chk("lbu10", {r_e, r_d}, SUB ? {1'b0, 32'h000000AA} : {1'b1, 32'h0});

    xact(0, 2'd1, 1, 22, 0, 0, 0, r_d, r_e, r_l);
    chk("lhs22", {r_e, r_d}, SUB ? {1'b0, 32'hFFFFBEEF} : {1'b1, 32'h0});
    r0 = rd_cyc;
    xact(0, 2'd1, 0, 21, 0, 0, 0, r_d, r_e, r_l);
    chk("lh21_err", {r_e, r_d}, {1'b1, 32'h0});
    chk("lh21_lat", r_l, 1);
    chk("lh21_noread", rd_cyc - r0, 0);

    r0 = rd_cyc; w0 = wr_cyc;
    xact(0, 2'd2, 0, 256, 0, 0, 0, r_d, r_e, r_l);
    chk("lw256_err", {r_e, r_l[3:0]}, {1'b1, 4'd1});
    xact(1, 2'd3, 0, 0, 32'h12345678, 0, 0, r_d, r_e, r_l);
    chk("sz11_err", {r_e, r_l[3:0]}, {1'b1, 4'd1});
    chk("err_nostrobe", (rd_cyc - r0) + (wr_cyc - w0), 0);
    xact(1, 2'd2, 0, 252, 32'h0000005A, 0, 0, r_d, r_e, r_l);
    xact(0, 2'd0, 1, 255, 0, 0, 0, r_d, r_e, r_l);
    chk("lb255", {r_e, r_d}, SUB ? {1'b0, 32'h0000005A} : {1'b1, 32'h0});

    xact(0, 2'd2, 0, 20, 0, 5, 1, r_d, r_e, r_l);
    chk("hold_lw20", {r_e, r_d}, {1'b0, 32'hDEADBEEF});

    old40 = {mem[40], mem[41], mem[42], mem[43]};
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd2; reqAddr = 40; reqData = ~old40; respReady = 1'b0;
    @(posedge clk); @(negedge clk);
    reqValid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) if (MemWrite) seen = 1'b1; else @(negedge clk);
    chk("arst_pulse_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", {MemRead, MemWrite}, 0);
    chk("arst_ready_valid", {reqReady, respValid}, 2'b10);
    chk("arst_bus", {memAddress, memWriteData}, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    chk("arst_mem40", {mem[40], mem[41], mem[42], mem[43]}, old40);
    xact(0, 2'd2, 0, 40, 0, 0, 0, r_d, r_e, r_l);
    chk("arst_lw40", {r_e, r_d}, {1'b0, old40});

    for (int t = 0; t < 200; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 15) == 0 ? $urandom : 32'($urandom_range(0, 259));
      if ($urandom_range(0, 3) != 0) a = a & ~(sz == 2'd2 ? 32'd3 : sz == 2'd1 ? 32'd1 : 32'd0);
      xact(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3), 1'($urandom), r_d, r_e, r_l);
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_m[i]) mism++;
    chk("final_mem_image", mism, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that drives the byte-addressed, big-endian data memory port (MemRead, MemWrite, address, write data, read data) on behalf of the CPU datapath. It accepts one byte/halfword/word request at a time over a valid/ready handshake. It checks alignment and range, performs read-modify-write for sub-word stores, and sign/zero-extends sub-word loads. It returns a response over a valid/ready handshake, and sequences the memory's level-sensitive strobes so that address and data are stable before any strobe rises.

## Interface
- MEM_BYTES, 256: memory size in bytes; multiple of 4; legal addresses 0..MEM_BYTES-1.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit idle and able to accept; reset 1.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- reqSigned  in  1  sign-extend sub-word load; ignored for stores/word.
- reqAddr  in  32  byte address.
- reqData  in  32  store data, right-justified for sub-word.
- respValid  out  1  response present; reset 0.
- respReady  in  1  consumer accepts response.
- respData  out  32  load result (extended); 0 for stores/errors; reset 0.
- respErr  out  1  misaligned, out-of-range or illegal-size request; reset 0.
- MemRead  out  1  memory read strobe; reset 0.
- MemWrite  out  1  memory write strobe; reset 0.
- memAddress  out  32  always word-aligned (reqAddr & ~3); reset 0.
- memWriteData  out  32  word to write; reset 0.
- memReadData  in  32  word from memory, valid while MemRead=1.

## Operation
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, RESP. Reset state IDLE.
- IDLE: reqReady=1. Acceptance on an edge with reqValid=1. Request fields are latched.
- Error check at acceptance:
  - reqSize=11 is an error.
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - addr >= MEM_BYTES is an error.
  - On error go to RESP with respErr=1. No strobe is asserted.
- Load: IDLE -> RD -> RESP.
  - In RD, MemRead=1 and memAddress=aligned address.
  - At the end of RD, memReadData is captured.
  - The lane is selected big-endian: byte lane k=addr[1:0] is bits [31-8k -: 8]; halfword lane addr[1] selects bits 31:16 (0) or 15:0 (1).
  - The lane is zero- or sign-extended per reqSigned.
- Word store: IDLE -> WR_SETUP -> WR_PULSE -> RESP.
- Sub-word store: IDLE -> RD -> WR_SETUP -> WR_PULSE -> RESP.
  - The word read in RD has its lane replaced by reqData[7:0] or [15:0].
  - Other bytes are preserved exactly.
- WR_SETUP: memAddress and memWriteData are valid; MemWrite=0.
- WR_PULSE: MemWrite=1 for exactly one cycle; address and data unchanged.
- RESP: respValid=1 and held with stable respData/respErr until respReady=1. Then go to IDLE; respValid drops the next cycle.
- MemRead and MemWrite are never 1 simultaneously.
- MemRead and MemWrite are never 1 outside RD/WR_PULSE respectively.

## Timing
- All outputs are registered; no combinational path from req*/resp* inputs to outputs.
- Load latency: respValid rises 2 edges after the acceptance edge (RD, then RESP).
- Word-store latency: 3 edges. Sub-word store: 4 edges. Error: 1 edge.
- Throughput: one request in flight.
  - reqReady=0 from the acceptance edge until the cycle after the response handshake.
  - reqValid while busy is ignored (not latched).
- memAddress and memWriteData change only on entry to RD or WR_SETUP. Both are held through WR_PULSE and one further cycle (RESP).
- Reset asserted mid-operation clears MemWrite/MemRead immediately (asynchronously), returns the FSM to IDLE and drops respValid. An in-progress store either completed its WR_PULSE or did not write at all.
- Highest legal byte (MEM_BYTES-1) accesses aligned word MEM_BYTES-4; no wrap past memory end.

## Configuration
- MAU_SUBWORD_EN defined: byte/halfword loads and stores supported as above.
- MAU_SUBWORD_EN undefined:
  - Only word accesses are supported; reqSize 00/01 is flagged respErr=1 with no memory access.
  - The RD state is used for loads only; the lane-alignment logic is omitted.

## Structure
- Package mau_pkg:
  - Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state enum.
  - Default MEM_BYTES constant.
- Sub-module mau_lane_align (combinational):
  - Inputs: word, addr[1:0], size, signed, store data.
  - Outputs: extended load value and merged store word.
  - Compiled only under MAU_SUBWORD_EN.

## Test plan
- Word store 0xDEADBEEF @20, then word load @20 -> MemWrite one-cycle pulse; memory bytes 20..23 = DE,AD,BE,EF; respData=0xDEADBEEF, respErr=0.
- Preload word 0x11223344 @8; byte store 0xAA @10 -> RD then write of 0x1122AA44; signed byte load @10 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Halfword load signed @22 after first test -> 0xFFFFBEEF; halfword load @21 -> respErr=1, MemRead never asserted.
- Word load @256 (MEM_BYTES=256) and reqSize=11 -> respErr=1 after 1 edge, no strobes; byte load @255 reads aligned word 252.
- Hold respReady=0 for 5 cycles in RESP -> respValid/respData stable, reqReady=0, new reqValid ignored; release -> IDLE.
- Assert rst_n low during WR_PULSE -> MemWrite drops without waiting for clk; all outputs return to reset values; next request executes normally.
